// File: rtl/stage1_fetch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | stage1_fetch: sequential instruction fetch with an in-order response   |
// | queue driving the IF/ID pipeline register; honours stall and redirect. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module stage1_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hazard,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] if_id_ir,
  output logic [31:0] if_id_npc
);

  localparam int            c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            c_cw    = c_aw + 1;
  localparam logic [c_cw:0] c_depth = (c_cw + 1)'(DEPTH);

  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_q_pc [DEPTH];
  logic [31:0]     r_q_ir [DEPTH];
  logic [DEPTH-1:0] r_q_filled;
  logic [c_aw-1:0] r_head;
  logic [c_aw-1:0] r_tail;
  logic [c_aw-1:0] r_fptr;
  logic [c_cw-1:0] r_used;
  logic [c_cw-1:0] r_unfilled;
  logic [c_cw-1:0] r_drop_cnt;
  logic [31:0]     r_if_id_ir;
  logic [31:0]     r_if_id_npc;

  logic w_room;
  logic w_req_valid;
  logic w_alloc;
  logic w_rsp_drop;
  logic w_fill;
  logic w_head_ready;
  logic w_pop;

  // Slots still owed a response (stale drops) count against capacity too.
  assign w_room       = ({1'b0, r_used} + {1'b0, r_drop_cnt}) < c_depth;
  assign w_req_valid  = !reset && !redirect_valid && w_room;
  assign w_alloc      = w_req_valid && imem_req_ready;
  assign w_rsp_drop   = imem_rsp_valid && (r_drop_cnt != '0);
  assign w_fill       = imem_rsp_valid && (r_drop_cnt == '0);
  assign w_head_ready = (r_used != '0) && r_q_filled[r_head];
  assign w_pop        = !redirect_valid && !hazard && w_head_ready;

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign if_id_ir       = r_if_id_ir;
  assign if_id_npc      = r_if_id_npc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc  <= RESET_PC;
      r_q_filled  <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_fptr      <= '0;
      r_used      <= '0;
      r_unfilled  <= '0;
      r_drop_cnt  <= '0;
      r_if_id_ir  <= '0;
      r_if_id_npc <= '0;
    end else if (redirect_valid) begin
      // A response landing now belongs to an unfilled entry already counted.
      r_fetch_pc <= redirect_pc;
      r_head     <= r_tail;
      r_fptr     <= r_tail;
      r_used     <= '0;
      r_unfilled <= '0;
      r_drop_cnt <= r_drop_cnt - c_cw'(w_rsp_drop) + r_unfilled - c_cw'(w_fill);
      r_if_id_ir <= '0;
    end else begin
      if (w_alloc) begin
        r_fetch_pc         <= r_fetch_pc + 32'd4;
        r_q_filled[r_tail] <= 1'b0;
        r_tail             <= r_tail + c_aw'(1);
      end
      if (w_fill) begin
        r_q_filled[r_fptr] <= 1'b1;
        r_fptr             <= r_fptr + c_aw'(1);
      end
      if (w_pop) begin
        r_head      <= r_head + c_aw'(1);
        r_if_id_ir  <= r_q_ir[r_head];
        r_if_id_npc <= r_q_pc[r_head] + 32'd4;
      end else if (!hazard) begin
        r_if_id_ir <= '0;
      end
      r_used     <= r_used + c_cw'(w_alloc) - c_cw'(w_pop);
      r_unfilled <= r_unfilled + c_cw'(w_alloc) - c_cw'(w_fill);
      r_drop_cnt <= r_drop_cnt - c_cw'(w_rsp_drop);
    end
  end

  // Payload storage needs no reset; validity lives in the counters and flags.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_q_pc[r_tail] <= r_fetch_pc;
    end
    if (w_fill && !redirect_valid) begin
      r_q_ir[r_fptr] <= imem_rsp_data;
    end
  end

  a_occupancy: assert property (@(posedge clk) disable iff (reset)
    ({1'b0, r_used} + {1'b0, r_drop_cnt}) <= c_depth);

  a_req_align: assert property (@(posedge clk) disable iff (reset)
    imem_req_valid |-> (imem_req_addr[1:0] == 2'b00));

  a_rsp_expected: assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> ((r_drop_cnt != '0) || (r_unfilled != '0)));

endmodule
`default_nettype wire

// File: tb/tb_stage1_fetch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_stage1_fetch: directed vectors and corner sequences for the fetch   |
// | stage against a simple in-order instruction memory.                    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_stage1_fetch;

  localparam logic [31:0] c_reset_pc = 32'h0000_0100;
  localparam logic [31:0] c_xor      = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        hazard;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] if_id_ir;
  logic [31:0] if_id_npc;

  stage1_fetch #(.RESET_PC(c_reset_pc), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .hazard         (hazard),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_id_ir       (if_id_ir),
    .if_id_npc      (if_id_npc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hz;
    logic        rdy;
    logic        vld;
    logic [31:0] addr;
    logic [31:0] ir;
    logic [31:0] npc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] npc;
  } got_t;

  mreq_t mq[$];
  got_t  got[$];
  int    cycle;
  int    lat;
  int    tests;
  int    fails;
  vec_t  tv[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: memory answers in order once due, accepted requests are queued.
  task automatic cyc();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cycle) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].addr ^ c_xor;
      void'(mq.pop_front());
    end
    #1;
    if (imem_req_valid && imem_req_ready)
      mq.push_back('{imem_req_addr, cycle + lat});
    @(posedge clk);
    #1;
    cycle++;
    if (if_id_ir != 32'h0)
      got.push_back('{if_id_ir, if_id_npc});
  endtask

  task automatic run_until(input string nm, input int n, input int budget);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      cyc();
      k++;
    end
    if (got.size() < n) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d instrs expected %0d", nm, got.size(), n);
    end
  endtask

  task automatic expect_seq(input string nm, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (i < got.size()) begin
        chk($sformatf("%s_ir%0d", nm, i), got[i].ir, (base + 32'(4 * i)) ^ c_xor);
        chk($sformatf("%s_npc%0d", nm, i), got[i].npc, base + 32'(4 * i) + 32'd4);
      end
    end
  endtask

  initial begin
    logic [31:0] npc_before;
    bit          found;
    tests = 0;
    fails = 0;
    cycle = 0;
    lat   = 1;
    // 1-cycle memory, then 3-cycle hazard, then 4 cycles of ready low
    tv[0]  = '{1'b0, 1'b1, 1'b1, 32'h100, 32'h0,         32'h0};
    tv[1]  = '{1'b0, 1'b1, 1'b1, 32'h104, 32'h0,         32'h0};
    tv[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,   32'hA5A50100, 32'h104};
    tv[3]  = '{1'b0, 1'b1, 1'b1, 32'h108, 32'hA5A50104, 32'h108};
    tv[4]  = '{1'b0, 1'b1, 1'b1, 32'h10C, 32'h0,         32'h108};
    tv[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,   32'hA5A50108, 32'h10C};
    tv[6]  = '{1'b0, 1'b1, 1'b1, 32'h110, 32'hA5A5010C, 32'h110};
    tv[7]  = '{1'b0, 1'b1, 1'b1, 32'h114, 32'h0,         32'h110};
    tv[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,   32'hA5A50110, 32'h114};
    tv[9]  = '{1'b0, 1'b1, 1'b1, 32'h118, 32'hA5A50114, 32'h118};
    tv[10] = '{1'b1, 1'b1, 1'b1, 32'h11C, 32'hA5A50114, 32'h118};
    tv[11] = '{1'b1, 1'b1, 1'b0, 32'h0,   32'hA5A50114, 32'h118};
    tv[12] = '{1'b1, 1'b1, 1'b0, 32'h0,   32'hA5A50114, 32'h118};
    tv[13] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'hA5A50118, 32'h11C};
    tv[14] = '{1'b0, 1'b1, 1'b1, 32'h120, 32'hA5A5011C, 32'h120};
    tv[15] = '{1'b0, 1'b1, 1'b1, 32'h124, 32'h0,         32'h120};
    tv[16] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'hA5A50120, 32'h124};
    tv[17] = '{1'b0, 1'b0, 1'b1, 32'h128, 32'hA5A50124, 32'h128};
    tv[18] = '{1'b0, 1'b0, 1'b1, 32'h128, 32'h0,         32'h128};
    tv[19] = '{1'b0, 1'b0, 1'b1, 32'h128, 32'h0,         32'h128};

    reset          = 1'b1;
    hazard         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, c_reset_pc);
    chk("rst_ir", if_id_ir, 32'h0);
    chk("rst_npc", if_id_npc, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      hazard         = tv[i].hz;
      imem_req_ready = tv[i].rdy;
      #1;
      chk($sformatf("v%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, tv[i].vld});
      if (tv[i].vld)
        chk($sformatf("v%0d_req_addr", i), imem_req_addr, tv[i].addr);
      cyc();
      chk($sformatf("v%0d_ir", i), if_id_ir, tv[i].ir);
      chk($sformatf("v%0d_npc", i), if_id_npc, tv[i].npc);
    end

    // slow memory after the stall: instructions keep address order
    got.delete();
    lat            = 3;
    imem_req_ready = 1'b1;
    run_until("slow", 6, 60);
    expect_seq("slow", 32'h128, 6);

    // drain, then redirect with two requests outstanding
    imem_req_ready = 1'b0;
    for (int k = 0; k < 20 && mq.size() > 0; k++) cyc();
    for (int k = 0; k < 4; k++) cyc();
    imem_req_ready = 1'b1;
    cyc();
    cyc();
    chk("rd_outstanding", mq.size(), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    npc_before     = if_id_npc;
    #1;
    chk("rd_no_req", {31'b0, imem_req_valid}, 32'h0);
    cyc();
    chk("rd_ir", if_id_ir, 32'h0);
    chk("rd_npc_held", if_id_npc, npc_before);
    redirect_valid = 1'b0;
    got.delete();
    lat = 1;
    run_until("rd", 2, 30);
    expect_seq("rd", 32'h2000, 2);

    // redirect plus hazard in a cycle where a live response arrives
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (mq.size() > 0 && mq[0].due <= cycle) found = 1'b1;
      else cyc();
    end
    chk("rh_rsp_cycle_found", {31'b0, found}, 32'h1);
    redirect_valid = 1'b1;
    hazard         = 1'b1;
    redirect_pc    = 32'h0000_3000;
    npc_before     = if_id_npc;
    #1;
    chk("rh_no_req", {31'b0, imem_req_valid}, 32'h0);
    cyc();
    chk("rh_ir", if_id_ir, 32'h0);
    chk("rh_npc_held", if_id_npc, npc_before);
    redirect_valid = 1'b0;
    hazard         = 1'b0;
    got.delete();
    run_until("rh", 3, 30);
    expect_seq("rh", 32'h3000, 3);

    // fill the queue under stall, then reset asynchronously mid-cycle
    hazard = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    #1;
    chk("full_no_req", {31'b0, imem_req_valid}, 32'h0);
    #2;
    reset          = 1'b1;
    imem_rsp_valid = 1'b0;
    #1;
    chk("arst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("arst_ir", if_id_ir, 32'h0);
    chk("arst_npc", if_id_npc, 32'h0);
    mq.delete();
    @(posedge clk);
    #1;
    reset  = 1'b0;
    hazard = 1'b0;
    #1;
    chk("post_rst_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("post_rst_addr", imem_req_addr, c_reset_pc);
    got.delete();
    run_until("post_rst", 2, 20);
    expect_seq("post_rst", c_reset_pc, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
